// File: rtl/ahb_lite_master_bridge_if.sv
// Core-side request/completion channel and AHB-Lite master bus, bundled for the bridge.
interface ahb_lite_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Core request side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_fn3;
  logic [31:0]       mem_wdata;

  // Core completion side
  logic              done;
  logic              done_is_fetch;
  logic [31:0]       rdata;
  logic              err;
  logic [1:0]        err_code;
  logic              busy;

  // AHB-Lite master bus
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [3:0]        hprot;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  // Bridge side
  modport master (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_fn3, mem_wdata,
    output done, done_is_fetch, rdata, err, err_code, busy,
    output haddr, htrans, hwrite, hsize, hprot, hwdata,
    input  hready, hresp, hrdata
  );

  // Core plus bus-slave side
  modport slave (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_fn3, mem_wdata,
    input  done, done_is_fetch, rdata, err, err_code, busy,
    input  haddr, htrans, hwrite, hsize, hprot, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ahb_lite_master_bridge.sv
// Merges the core's fetch and load/store channels onto one AHB-Lite master port.
// Load/store wins arbitration; illegal requests complete without a bus transfer.
module ahb_lite_master_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                     clk,
  input logic                     reset,
  ahb_lite_master_bridge_if.master bus
);

  localparam int unsigned OffW = $clog2(DATA_W / 8);
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrBus     = 2'b01;
  localparam logic [1:0] ErrIllegal = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StErr2,
    StResp
  } state_e;

  state_e            state_q;
  logic              fetch_q;
  logic [2:0]        fn3_q;
  logic [31:0]       wdata_q;
  logic [CntW-1:0]   cnt_q;

  logic              sel_mem;
  logic              req_valid;
  logic              req_we;
  logic              req_legal;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_fn3;
  logic [OffW-1:0]   lane_off;
  logic [DATA_W-1:0] lane_shift;
  logic [31:0]       lane_word;
  logic [31:0]       load_data;
  logic [DATA_W-1:0] store_lanes;
  logic              to_hit;

  // Request arbitration and legality of the request presented in IDLE
  always_comb begin
    sel_mem   = bus.mem_req;
    req_valid = bus.mem_req | bus.if_req;
    req_addr  = sel_mem ? bus.mem_addr : bus.if_addr;
    req_we    = sel_mem & bus.mem_we;
    req_fn3   = sel_mem ? bus.mem_fn3 : 3'b010;
    req_legal = 1'b0;
    if (!sel_mem) begin
      req_legal = (req_addr[1:0] == 2'b00);
    end else begin
      case (bus.mem_fn3)
        3'b000:  req_legal = 1'b1;
        3'b001:  req_legal = ~req_addr[0];
        3'b010:  req_legal = (req_addr[1:0] == 2'b00);
        3'b100:  req_legal = ~bus.mem_we;
        3'b101:  req_legal = ~bus.mem_we & ~req_addr[0];
        default: req_legal = 1'b0;
      endcase
    end
  end

  // Read lane selection and sign/zero extension of the captured transfer
  always_comb begin
    lane_off   = bus.haddr[OffW-1:0];
    lane_shift = bus.hrdata >> {lane_off, 3'b000};
    lane_word  = lane_shift[31:0];
    case (fn3_q)
      3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_data = {24'b0, lane_word[7:0]};
      3'b101:  load_data = {16'b0, lane_word[15:0]};
      default: load_data = lane_word;
    endcase
  end

  // Store data replicated across every lane of its size
  always_comb begin
    case (fn3_q[1:0])
      2'b00:   store_lanes = {(DATA_W / 8){wdata_q[7:0]}};
      2'b01:   store_lanes = {(DATA_W / 16){wdata_q[15:0]}};
      default: store_lanes = {(DATA_W / 32){wdata_q}};
    endcase
  end

  // Wait-state abort: this hready=0 cycle is the TIMEOUT-th in a row
  always_comb begin
    if (TIMEOUT == 0) begin
      to_hit = 1'b0;
    end else begin
      to_hit = (cnt_q == CntW'(TIMEOUT - 1));
    end
  end

  // Transfer FSM with registered bus and completion outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StIdle;
      fetch_q           <= 1'b0;
      fn3_q             <= 3'b010;
      wdata_q           <= '0;
      cnt_q             <= '0;
      bus.haddr         <= '0;
      bus.htrans        <= 2'b00;
      bus.hwrite        <= 1'b0;
      bus.hsize         <= 3'b010;
      bus.hprot         <= 4'b0011;
      bus.hwdata        <= '0;
      bus.done          <= 1'b0;
      bus.done_is_fetch <= 1'b0;
      bus.rdata         <= '0;
      bus.err           <= 1'b0;
      bus.err_code      <= ErrOk;
      bus.busy          <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            fetch_q  <= ~sel_mem;
            fn3_q    <= req_fn3;
            wdata_q  <= bus.mem_wdata;
            cnt_q    <= '0;
            bus.busy <= 1'b1;
            if (req_legal) begin
              bus.haddr  <= req_addr;
              bus.htrans <= 2'b10;
              bus.hwrite <= req_we;
              bus.hsize  <= sel_mem ? {1'b0, req_fn3[1:0]} : 3'b010;
              bus.hprot  <= sel_mem ? 4'b0011 : 4'b0010;
              state_q    <= StAddr;
            end else begin
              state_q           <= StResp;
              bus.done          <= 1'b1;
              bus.done_is_fetch <= ~sel_mem;
              bus.rdata         <= '0;
              bus.err           <= 1'b1;
              bus.err_code      <= ErrIllegal;
            end
          end
        end

        StAddr: begin
          if (bus.hready) begin
            bus.htrans <= 2'b00;
            cnt_q      <= '0;
            state_q    <= StData;
            if (bus.hwrite) begin
              bus.hwdata <= store_lanes;
            end
          end else if (to_hit) begin
            bus.htrans        <= 2'b00;
            state_q           <= StResp;
            bus.done          <= 1'b1;
            bus.done_is_fetch <= fetch_q;
            bus.rdata         <= '0;
            bus.err           <= 1'b1;
            bus.err_code      <= ErrTimeout;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StData: begin
          if (bus.hresp) begin
            if (bus.hready) begin
              // Single-cycle ERROR is still reported as a bus error
              state_q           <= StResp;
              bus.done          <= 1'b1;
              bus.done_is_fetch <= fetch_q;
              bus.rdata         <= '0;
              bus.err           <= 1'b1;
              bus.err_code      <= ErrBus;
            end else begin
              cnt_q   <= '0;
              state_q <= StErr2;
            end
          end else if (bus.hready) begin
            state_q           <= StResp;
            bus.done          <= 1'b1;
            bus.done_is_fetch <= fetch_q;
            bus.rdata         <= bus.hwrite ? 32'b0 : load_data;
            bus.err           <= 1'b0;
            bus.err_code      <= ErrOk;
          end else if (to_hit) begin
            state_q           <= StResp;
            bus.done          <= 1'b1;
            bus.done_is_fetch <= fetch_q;
            bus.rdata         <= '0;
            bus.err           <= 1'b1;
            bus.err_code      <= ErrTimeout;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StErr2: begin
          if (bus.hready) begin
            state_q           <= StResp;
            bus.done          <= 1'b1;
            bus.done_is_fetch <= fetch_q;
            bus.rdata         <= '0;
            bus.err           <= 1'b1;
            bus.err_code      <= ErrBus;
          end else if (to_hit) begin
            state_q           <= StResp;
            bus.done          <= 1'b1;
            bus.done_is_fetch <= fetch_q;
            bus.rdata         <= '0;
            bus.err           <= 1'b1;
            bus.err_code      <= ErrTimeout;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StResp: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          cnt_q    <= '0;
          state_q  <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Directed bench for the AHB-Lite master bridge: 32-bit instance with TIMEOUT=4 and a
// 64-bit instance for lane steering.
module tb_ahb_lite_master_bridge;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ahb_lite_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) b32 ();
  ahb_lite_master_bridge_if #(.ADDR_W(32), .DATA_W(64)) b64 ();

  ahb_lite_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut32 (
    .clk  (clk),
    .reset(reset),
    .bus  (b32.master)
  );

  ahb_lite_master_bridge #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(16)) dut64 (
    .clk  (clk),
    .reset(reset),
    .bus  (b64.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Zero-wait load on the 32-bit instance; done expected in cycle 3
  task automatic load32(input string tag, input logic [31:0] addr, input logic [2:0] fn3,
                        input logic [31:0] hr, input logic [31:0] exp);
    b32.mem_req   = 1'b1;
    b32.mem_we    = 1'b0;
    b32.mem_addr  = addr;
    b32.mem_fn3   = fn3;
    b32.hrdata    = hr;
    b32.hready    = 1'b1;
    b32.hresp     = 1'b0;
    tick();
    b32.mem_req = 1'b0;
    check({tag, "_htrans"}, 64'(b32.htrans), 64'(2'b10));
    check({tag, "_hsize"}, 64'(b32.hsize), 64'({1'b0, fn3[1:0]}));
    tick();
    check({tag, "_nodone2"}, 64'(b32.done), 64'(1'b0));
    tick();
    check({tag, "_done"}, 64'(b32.done), 64'(1'b1));
    check({tag, "_rdata"}, 64'(b32.rdata), 64'(exp));
    tick();
  endtask

  // Zero-wait transfer on the 64-bit instance
  task automatic xfer64(input string tag, input logic we, input logic [31:0] addr,
                        input logic [2:0] fn3, input logic [31:0] wd, input logic [63:0] hr,
                        input logic [63:0] exp_hwdata, input logic [31:0] exp_rdata);
    b64.mem_req   = 1'b1;
    b64.mem_we    = we;
    b64.mem_addr  = addr;
    b64.mem_fn3   = fn3;
    b64.mem_wdata = wd;
    b64.hrdata    = hr;
    b64.hready    = 1'b1;
    b64.hresp     = 1'b0;
    tick();
    b64.mem_req = 1'b0;
    check({tag, "_htrans"}, 64'(b64.htrans), 64'(2'b10));
    tick();
    if (we) check({tag, "_hwdata"}, b64.hwdata, exp_hwdata);
    tick();
    check({tag, "_done"}, 64'(b64.done), 64'(1'b1));
    if (!we) check({tag, "_rdata"}, 64'(b64.rdata), 64'(exp_rdata));
    tick();
    b64.mem_we = 1'b0;
  endtask

  initial begin
    b32.if_req = 0; b32.if_addr = '0; b32.mem_req = 0; b32.mem_we = 0; b32.mem_addr = '0;
    b32.mem_fn3 = 3'b010; b32.mem_wdata = '0; b32.hready = 1; b32.hresp = 0; b32.hrdata = '0;
    b64.if_req = 0; b64.if_addr = '0; b64.mem_req = 0; b64.mem_we = 0; b64.mem_addr = '0;
    b64.mem_fn3 = 3'b010; b64.mem_wdata = '0; b64.hready = 1; b64.hresp = 0; b64.hrdata = '0;

    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_htrans", 64'(b32.htrans), 64'(2'b00));
    check("rst_haddr", 64'(b32.haddr), 64'h0);
    check("rst_hsize", 64'(b32.hsize), 64'(3'b010));
    check("rst_hprot", 64'(b32.hprot), 64'(4'b0011));
    check("rst_hwrite", 64'(b32.hwrite), 64'(1'b0));
    check("rst_hwdata", 64'(b32.hwdata), 64'h0);
    check("rst_done", 64'(b32.done), 64'(1'b0));
    check("rst_busy", 64'(b32.busy), 64'(1'b0));
    check("rst_errcode", 64'(b32.err_code), 64'(2'b00));
    check("rst_rdata", 64'(b32.rdata), 64'h0);

    // Zero-wait LW
    b32.mem_req = 1; b32.mem_we = 0; b32.mem_addr = 32'h0000_1004; b32.mem_fn3 = 3'b010;
    b32.hrdata = 32'hDEAD_BEEF;
    tick();
    b32.mem_req = 0;
    check("lw_htrans_c1", 64'(b32.htrans), 64'(2'b10));
    check("lw_haddr_c1", 64'(b32.haddr), 64'h1004);
    check("lw_hsize_c1", 64'(b32.hsize), 64'(3'b010));
    check("lw_hprot_c1", 64'(b32.hprot), 64'(4'b0011));
    check("lw_hwrite_c1", 64'(b32.hwrite), 64'(1'b0));
    check("lw_busy_c1", 64'(b32.busy), 64'(1'b1));
    tick();
    check("lw_htrans_c2", 64'(b32.htrans), 64'(2'b00));
    check("lw_done_c2", 64'(b32.done), 64'(1'b0));
    tick();
    check("lw_done_c3", 64'(b32.done), 64'(1'b1));
    check("lw_rdata_c3", 64'(b32.rdata), 64'hDEAD_BEEF);
    check("lw_err_c3", 64'(b32.err), 64'(1'b0));
    check("lw_isfetch_c3", 64'(b32.done_is_fetch), 64'(1'b0));
    tick();
    check("lw_done_c4", 64'(b32.done), 64'(1'b0));
    check("lw_busy_c4", 64'(b32.busy), 64'(1'b0));

    // SB with two DATA wait states
    b32.mem_req = 1; b32.mem_we = 1; b32.mem_addr = 32'h0000_2003; b32.mem_fn3 = 3'b000;
    b32.mem_wdata = 32'h0000_00A5;
    tick();
    b32.mem_req = 0;
    check("sb_hsize", 64'(b32.hsize), 64'(3'b000));
    check("sb_hwrite", 64'(b32.hwrite), 64'(1'b1));
    tick();
    b32.hready = 0;
    check("sb_hwdata_c2", 64'(b32.hwdata), 64'hA5A5_A5A5);
    tick();
    check("sb_hwdata_c3", 64'(b32.hwdata), 64'hA5A5_A5A5);
    check("sb_nodone_c3", 64'(b32.done), 64'(1'b0));
    tick();
    b32.hready = 1;
    check("sb_hwdata_c4", 64'(b32.hwdata), 64'hA5A5_A5A5);
    check("sb_nodone_c4", 64'(b32.done), 64'(1'b0));
    tick();
    check("sb_done_c5", 64'(b32.done), 64'(1'b1));
    check("sb_err_c5", 64'(b32.err), 64'(1'b0));
    tick();
    b32.mem_we = 0;

    // Load extension
    load32("lb", 32'h0000_3002, 3'b000, 32'h0080_0000, 32'hFFFF_FF80);
    load32("lbu", 32'h0000_3002, 3'b100, 32'h0080_0000, 32'h0000_0080);
    load32("lh", 32'h0000_3002, 3'b001, 32'h8001_0000, 32'hFFFF_8001);
    load32("lhu", 32'h0000_3002, 3'b101, 32'h8001_0000, 32'h0000_8001);
    load32("lb_pos", 32'h0000_3001, 3'b000, 32'h0000_7F00, 32'h0000_007F);

    // 64-bit lane steering
    xfer64("lw64_hi", 1'b0, 32'h0000_0004, 3'b010, 32'h0, 64'h1234_5678_9ABC_DEF0, 64'h0,
           32'h1234_5678);
    xfer64("lw64_lo", 1'b0, 32'h0000_0000, 3'b010, 32'h0, 64'h1234_5678_9ABC_DEF0, 64'h0,
           32'h9ABC_DEF0);
    xfer64("lbu64_b5", 1'b0, 32'h0000_0005, 3'b100, 32'h0, 64'h0000_C300_0000_0000, 64'h0,
           32'h0000_00C3);
    xfer64("sw64", 1'b1, 32'h0000_0008, 3'b010, 32'hCAFE_F00D, 64'h0,
           64'hCAFE_F00D_CAFE_F00D, 32'h0);
    xfer64("sh64", 1'b1, 32'h0000_0002, 3'b001, 32'h0000_BEEF, 64'h0,
           64'hBEEF_BEEF_BEEF_BEEF, 32'h0);

    // Simultaneous fetch and load: load wins, fetch held until re-sampled
    b32.if_req = 1; b32.if_addr = 32'h0000_0100;
    b32.mem_req = 1; b32.mem_we = 0; b32.mem_addr = 32'h0000_3000; b32.mem_fn3 = 3'b010;
    b32.hrdata = 32'h0000_0013;
    tick();
    b32.mem_req = 0;
    check("arb_hprot", 64'(b32.hprot), 64'(4'b0011));
    check("arb_haddr", 64'(b32.haddr), 64'h3000);
    tick();
    tick();
    check("arb_done", 64'(b32.done), 64'(1'b1));
    check("arb_isfetch", 64'(b32.done_is_fetch), 64'(1'b0));
    tick();
    check("arb_idle_htrans", 64'(b32.htrans), 64'(2'b00));
    tick();
    b32.if_req = 0;
    check("fetch_htrans", 64'(b32.htrans), 64'(2'b10));
    check("fetch_haddr", 64'(b32.haddr), 64'h0100);
    check("fetch_hprot", 64'(b32.hprot), 64'(4'b0010));
    check("fetch_hsize", 64'(b32.hsize), 64'(3'b010));
    tick();
    tick();
    check("fetch_done", 64'(b32.done), 64'(1'b1));
    check("fetch_isfetch", 64'(b32.done_is_fetch), 64'(1'b1));
    check("fetch_rdata", 64'(b32.rdata), 64'h13);
    tick();

    // Misaligned LH: immediate error, no bus transfer
    b32.mem_req = 1; b32.mem_we = 0; b32.mem_addr = 32'h0000_4001; b32.mem_fn3 = 3'b001;
    tick();
    b32.mem_req = 0;
    check("mis_htrans", 64'(b32.htrans), 64'(2'b00));
    check("mis_done", 64'(b32.done), 64'(1'b1));
    check("mis_errcode", 64'(b32.err_code), 64'(2'b10));
    check("mis_err", 64'(b32.err), 64'(1'b1));
    tick();
    check("mis_htrans2", 64'(b32.htrans), 64'(2'b00));
    check("mis_done2", 64'(b32.done), 64'(1'b0));

    // Store with a load-only fn3 code is illegal
    b32.mem_req = 1; b32.mem_we = 1; b32.mem_addr = 32'h0000_4000; b32.mem_fn3 = 3'b100;
    tick();
    b32.mem_req = 0; b32.mem_we = 0;
    check("ill_st_errcode", 64'(b32.err_code), 64'(2'b10));
    check("ill_st_htrans", 64'(b32.htrans), 64'(2'b00));
    tick();

    // Misaligned fetch
    b32.if_req = 1; b32.if_addr = 32'h0000_0102;
    tick();
    b32.if_req = 0;
    check("mis_if_errcode", 64'(b32.err_code), 64'(2'b10));
    check("mis_if_isfetch", 64'(b32.done_is_fetch), 64'(1'b1));
    tick();

    // Two-cycle bus ERROR
    b32.mem_req = 1; b32.mem_we = 0; b32.mem_addr = 32'h0000_5000; b32.mem_fn3 = 3'b010;
    b32.hrdata = 32'hFFFF_FFFF;
    tick();
    b32.mem_req = 0;
    tick();
    b32.hresp = 1; b32.hready = 0;
    tick();
    b32.hready = 1;
    check("berr_nodone", 64'(b32.done), 64'(1'b0));
    tick();
    b32.hresp = 0;
    check("berr_done", 64'(b32.done), 64'(1'b1));
    check("berr_errcode", 64'(b32.err_code), 64'(2'b01));
    check("berr_rdata", 64'(b32.rdata), 64'h0);
    tick();

    // Timeout in the address phase (TIMEOUT=4)
    b32.mem_req = 1; b32.mem_we = 0; b32.mem_addr = 32'h0000_6000; b32.mem_fn3 = 3'b010;
    tick();
    b32.mem_req = 0;
    b32.hready = 0;
    check("to_htrans_c1", 64'(b32.htrans), 64'(2'b10));
    tick();
    tick();
    tick();
    check("to_htrans_c4", 64'(b32.htrans), 64'(2'b10));
    check("to_nodone_c4", 64'(b32.done), 64'(1'b0));
    tick();
    check("to_htrans_c5", 64'(b32.htrans), 64'(2'b00));
    check("to_done_c5", 64'(b32.done), 64'(1'b1));
    check("to_errcode_c5", 64'(b32.err_code), 64'(2'b11));
    b32.hready = 1;
    tick();
    load32("after_to", 32'h0000_6004, 3'b010, 32'h0BAD_F00D, 32'h0BAD_F00D);

    // Reset during the data phase
    b32.mem_req = 1; b32.mem_we = 0; b32.mem_addr = 32'h0000_7000; b32.mem_fn3 = 3'b010;
    tick();
    b32.mem_req = 0;
    tick();
    b32.hready = 0;
    reset = 1;
    tick();
    reset = 0;
    b32.hready = 1;
    check("rstd_htrans", 64'(b32.htrans), 64'(2'b00));
    check("rstd_busy", 64'(b32.busy), 64'(1'b0));
    check("rstd_done", 64'(b32.done), 64'(1'b0));
    load32("after_rst", 32'h0000_7008, 3'b010, 32'h5555_AAAA, 32'h5555_AAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master_bridge.md
Name: ahb_lite_master_bridge

Overview:
- Parametrised successor to the core's fixed AHB-Lite glue: merges the core's separate fetch and load/store request channels onto one AHB-Lite master port.
- Generalised data width, fixed fetch/data priority, byte-lane steering, load sign extension, two-cycle ERROR handling, misalignment trapping and a wait-state timeout.
- Sits between the multicycle RISC-V core and the AHB interconnect.

Parameters:
- ADDR_W, 32, haddr and request address width.
- DATA_W, 32, AHB data bus width; legal values are 32 or 64. Core-side data is always 32 bits.
- TIMEOUT, 16, number of consecutive hready=0 cycles in one transfer before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; sampled only in IDLE.
- if_addr  in  ADDR_W  fetch address.
- mem_req  in  1  load/store request; sampled only in IDLE.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_W  load/store address.
- mem_fn3  in  3  RISC-V funct3 size/sign code.
- mem_wdata  in  32  store data, right-aligned.
- done  out  1  one-cycle completion pulse.
- done_is_fetch  out  1  channel that completed; valid while done=1.
- rdata  out  32  fetch word or extended load data; valid while done=1.
- err  out  1  completion carried an error.
- err_code  out  2  00 ok, 01 bus ERROR, 10 misaligned/illegal fn3, 11 timeout.
- busy  out  1  high in any state other than IDLE.
- haddr  out  ADDR_W  AHB address.
- htrans  out  2  AHB transfer type; only IDLE (00) and NONSEQ (10) are used.
- hwrite  out  1  AHB write.
- hsize  out  3  AHB transfer size.
- hprot  out  4  AHB protection.
- hwdata  out  DATA_W  AHB write data.
- hready  in  1  AHB ready.
- hresp  in  1  AHB response; 1 = ERROR.
- hrdata  in  DATA_W  AHB read data.

Behaviour:
- Reset outputs: htrans=00, haddr=0, hwrite=0, hsize=010, hprot=0011, hwdata=0, done=0, done_is_fetch=0, rdata=0, err=0, err_code=00, busy=0; state=IDLE. Reset asserted in any state aborts the transfer; htrans reads 00 from the next cycle.
- FSM states: IDLE, ADDR, DATA, ERR2, RESP.
- IDLE:
  - If mem_req=1, capture the mem channel. mem_req wins over a simultaneous if_req; the losing if_req is ignored and the core must re-present it.
  - Else if if_req=1, capture the fetch channel.
  - Legality check on capture:
    - Fetch: addr[1:0] must be 0.
    - Load fn3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Store fn3: 000 SB, 001 SH, 010 SW.
    - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - Illegal request: go to RESP with err_code=10; no bus transfer is issued.
  - Legal request: go to ADDR.
- ADDR:
  - Drive htrans=10 and captured haddr.
  - hsize = 010 for fetch, else {1'b0, fn3[1:0]}.
  - hwrite = mem_we (0 for fetch).
  - hprot = 0010 for fetch (opcode, privileged), 0011 for data.
  - Hold all address-phase signals while hready=0. On hready=1, go to DATA.
- DATA:
  - htrans=00. hwdata is driven for stores and held stable until hready=1.
  - Store lane replication: SB replicates byte [7:0] across all byte lanes; SH replicates [15:0] across all halfword lanes; SW replicates across word lanes when DATA_W=64.
  - hready=1, hresp=0: capture the read lane and go to RESP with err_code=00.
  - hresp=1, hready=0: go to ERR2.
- ERR2: on hready=1, go to RESP with err_code=01; read data is discarded and rdata=0.
- Load lane selection: byte offset = addr[log2(DATA_W/8)-1:0]. Select the addressed byte, halfword or word, then extend:
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW and fetch: pass the word through.
- RESP:
  - done=1 for exactly one cycle, with rdata, err, err_code and done_is_fetch valid.
  - err=1 whenever err_code is not 00.
  - Next state is IDLE. Requests presented during RESP are ignored.
- Latency, zero-wait transfer: request sampled at edge 0, address phase in cycle 1, data phase in cycle 2, done in cycle 3. Each wait state adds one cycle. An illegal request reports done in cycle 1.
- Timeout (TIMEOUT > 0):
  - The counter clears on every state entry and counts consecutive hready=0 cycles in ADDR, DATA and ERR2.
  - When the count reaches TIMEOUT: force htrans=00, go to RESP with err_code=11.
  - The next request proceeds normally.
- Requests arriving while busy=1 are ignored; the core holds off until done.

Test Plan:
- Zero-wait LW, addr 0x0000_1004, hrdata=0xDEAD_BEEF -> htrans=10 in cycle 1; done in cycle 3 with rdata=0xDEADBEEF, err=0, hsize=010, hprot=0011.
- SB to addr 0x0000_2003, wdata=0x0000_00A5, 2 wait states in DATA -> hwdata=0xA5A5A5A5 held for 3 cycles; done in cycle 5; hsize=000, hwrite=1.
- LB addr 0x...02 with hrdata=0x0080_0000 -> rdata=0xFFFFFF80. LBU at the same address -> rdata=0x00000080. DATA_W=64: LW addr 0x...04 with hrdata[63:32]=0x12345678 -> rdata=0x12345678.
- if_req and mem_req in the same cycle -> mem transfer issued (hprot=0011), done_is_fetch=0; the fetch is not issued until re-presented after done.
- LH at addr 0x...01 -> no NONSEQ ever driven; done in cycle 1 with err_code=10. Bus ERROR (hresp=1, hready=0 then hresp=1, hready=1) -> done with err_code=01, rdata=0.
- TIMEOUT=4 with hready held 0 in ADDR -> htrans returns to 00 after 4 cycles, done with err_code=11. Reset asserted in DATA -> htrans=00, busy=0, done=0 on the next cycle.
